aes_ks_sequencer: RTL and testbench
===================================

Name: aes_ks_sequencer

Overview:
- Sequential controller that drives the combinational AES-128 key-schedule round block (KS_round: kin, kout, RCON) iteratively.
- Accepts a cipher key, then emits round keys 0..NROUNDS one per handshake, generating the RCON sequence internally.
- Sits between the key-load interface and the round datapath. Feeds round keys to the masked/unmasked round pipeline, with backpressure.

Parameters:
- NROUNDS, 10, index of the last round key emitted (AES-128 = 10); legal range 1..10.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_in  input  128  cipher key; byte i on [8i+7:8i], byte 0 = first FIPS-197 key byte
- in_valid  input  1  key_in valid
- in_ready  output  1  sequencer idle, can accept a key
- abort  input  1  synchronous cancel of the current schedule
- rk_out  output  128  current round key, same byte order as key_in
- rk_round  output  4  index of rk_out (0..NROUNDS)
- rk_last  output  1  rk_round == NROUNDS
- out_valid  output  1  rk_out/rk_round/rk_last valid
- out_ready  input  1  consumer accepts the round key
- busy  output  1  schedule in progress (not IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, rk_out=0, rk_round=0, rk_last=0, internal rcon=8'h01.
- All outputs are driven from registers. There is no combinational path from in_valid or out_ready to any output.
- Internal registers: key_reg[127:0], round[3:0], rcon[7:0]. One KS_round instance: kin=key_reg, RCON=rcon. rk_out = key_reg.
- State IDLE (in_ready=1, out_valid=0):
  - On in_valid&&in_ready: key_reg<=key_in, round<=0, rcon<=8'h01. Go to EMIT.
  - out_valid rises on the next cycle, so key 0 appears 1 cycle after acceptance.
- State EMIT (in_ready=0, out_valid=1, busy=1):
  - Outputs hold stable while out_ready=0.
  - On out_valid&&out_ready with round<NROUNDS: key_reg<=kout, round<=round+1, rcon<=xtime(rcon). Stay in EMIT.
    - xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
    - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - On out_valid&&out_ready with round==NROUNDS: go to IDLE. out_valid<=0, in_ready<=1. key_reg is retained.
- Throughput: one round key per cycle while out_ready is held high. A full schedule is NROUNDS+1 handshakes.
- Back-to-back schedules: in the cycle after the last handshake in_ready=1. A new key is accepted then, giving a 1-cycle bubble.
- abort: sampled every cycle and has priority over every handshake.
  - In EMIT: go to IDLE next cycle, out_valid=0, in_ready=1, rcon<=01. The concurrent out handshake still counts for the consumer, but the sequencer does not advance.
  - In IDLE: abort blocks acceptance that cycle (in_ready stays 1, key is not captured).
- in_valid while busy: ignored, with no capture and no error. The upstream must hold in_valid until in_ready.
- Reset mid-schedule: asynchronous return to reset values. A partial key sequence is never resumed.
- rk_round and rk_last are registered alongside key_reg and are always consistent with rk_out.

Test Plan:
- FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 constantly -> 11 keys on consecutive cycles.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1 only there.
  - in_ready returns 1 on the following cycle.
- Backpressure: same key, out_ready toggles 1,0,0,1 pseudo-randomly -> rk_out, rk_round and rk_last stay stable while stalled. The key sequence is identical to the first test. The internal RCON reaches 8'h36 at round 10.
- Abort: abort pulsed when rk_round=4 -> out_valid=0 and in_ready=1 the next cycle. A new key 000102...0f is accepted, rk_round restarts at 0, and its round-1 key is d6aa74fdd2af72fadaa678f1d6ab76fe.
- Back-to-back: in_valid held high with a second key during the whole first schedule -> second key captured exactly 1 cycle after the round-10 handshake, and no key is dropped or duplicated.
- Async reset: rst_n low at rk_round=7, released mid-cycle -> all outputs 0, in_ready=1 immediately, with no out_valid glitch after release.
- Parameter NROUNDS=3 -> exactly 4 keys emitted, rk_last on round 3, RCON values 01,02,04 used.

Source files
------------

// File: rtl/aes_ks_sequencer.sv
// AES-128 key-schedule sequencer: iterates one ks_round block to emit
// round keys 0..NROUNDS under a valid/ready handshake.

module ks_round (
  input  logic [127:0] kin,
  input  logic [7:0]   rcon,
  output logic [127:0] kout
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] t;
  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [31:0] w3;

  // RotWord + SubWord of word 3; byte 0 of each word sits in the low bits
  assign t = {SBOX[kin[103:96]],
              SBOX[kin[127:120]],
              SBOX[kin[119:112]],
              SBOX[kin[111:104]] ^ rcon};

  assign w0 = kin[31:0]   ^ t;
  assign w1 = kin[63:32]  ^ w0;
  assign w2 = kin[95:64]  ^ w1;
  assign w3 = kin[127:96] ^ w2;

  assign kout = {w3, w2, w1, w0};

endmodule

module aes_ks_sequencer #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [127:0] key_reg;
  logic [127:0] key_n;
  logic [3:0]   round;
  logic [3:0]   round_n;
  logic [7:0]   rcon;
  logic [7:0]   rcon_n;
  logic         last;
  logic         last_n;
  logic [127:0] kout;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  ks_round u_ks (
    .kin  (key_reg),
    .rcon (rcon),
    .kout (kout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      round   <= '0;
      rcon    <= 8'h01;
      last    <= 1'b0;
    end else begin
      state   <= state_n;
      key_reg <= key_n;
      round   <= round_n;
      rcon    <= rcon_n;
      last    <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = key_reg;
    round_n = round;
    rcon_n  = rcon;
    last_n  = last;
    unique case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          key_n   = key_in;
          round_n = '0;
          rcon_n  = 8'h01;
          last_n  = 1'b0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        // abort wins over a concurrent output handshake
        if (abort) begin
          rcon_n  = 8'h01;
          state_n = IDLE;
        end else if (out_ready) begin
          if (round == LAST) begin
            state_n = IDLE;
          end else begin
            key_n   = kout;
            round_n = round + 4'd1;
            rcon_n  = xtime(rcon);
            last_n  = (round + 4'd1) == LAST;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == EMIT);
  assign out_valid = (state == EMIT);
  assign rk_out    = key_reg;
  assign rk_round  = round;
  assign rk_last   = last;

endmodule

// File: tb/tb_aes_ks_sequencer.sv
// Directed bench for aes_ks_sequencer with an independent key-expansion
// model feeding a scoreboard of expected round keys.

module tb_aes_ks_sequencer;

  typedef struct packed {
    logic [127:0] k;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1B  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         in_valid;
  logic         abort;
  logic         out_ready;
  logic         in_valid3;
  logic         out_ready3;

  logic         in_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         out_valid;
  logic         busy;

  logic         in_ready3;
  logic [127:0] rk_out3;
  logic [3:0]   rk_round3;
  logic         rk_last3;
  logic         out_valid3;
  logic         busy3;

  exp_t       q[$];
  exp_t       q3[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sbox [256];

  always #5 clk = ~clk;

  aes_ks_sequencer #(.NROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  aes_ks_sequencer #(.NROUNDS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .abort     (abort),
    .rk_out    (rk_out3),
    .rk_round  (rk_round3),
    .rk_last   (rk_last3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .busy      (busy3)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a0,
                                      input logic [7:0] b0);
    logic [7:0] a = a0;
    logic [7:0] b = b0;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_sched(input logic [127:0] kf, input int nr,
                            input bit three);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    exp_t        e;
    w0 = kf[127:96];
    w1 = kf[95:64];
    w2 = kf[63:32];
    w3 = kf[31:0];
    rc = 8'h01;
    for (int r = 0; r <= nr; r++) begin
      e.k = bswap({w0, w1, w2, w3});
      e.r = 4'(r);
      e.l = (r == nr);
      if (three) q3.push_back(e);
      else q.push_back(e);
      t  = subw({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid && rk_round == r) return;
    end
    chk("wait_round_timeout", 128'(rk_round), 128'(r));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      step();
    end
    chk("wait_idle_timeout", 128'(busy), 128'd0);
  endtask

  // scoreboard + stall-stability monitors, sampled on the falling edge
  logic         st, st3;
  logic [127:0] hk, hk3;
  logic [3:0]   hr, hr3;
  logic         hl, hl3;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) st = 1'b0;
    else begin
      if (st) begin
        chk("hold_key", rk_out, hk);
        chk("hold_round", 128'(rk_round), 128'(hr));
        chk("hold_last", 128'(rk_last), 128'(hl));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_extra_key", 128'(q.size()), 128'd1);
        else begin
          e = q.pop_front();
          chk("sb_key", rk_out, e.k);
          chk("sb_round", 128'(rk_round), 128'(e.r));
          chk("sb_last", 128'(rk_last), 128'(e.l));
        end
      end
      st = out_valid && !out_ready && !abort;
      hk = rk_out;
      hr = rk_round;
      hl = rk_last;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) st3 = 1'b0;
    else begin
      if (st3) chk("hold3_key", rk_out3, hk3);
      if (st3) chk("hold3_round", 128'(rk_round3), 128'(hr3));
      if (st3) chk("hold3_last", 128'(rk_last3), 128'(hl3));
      if (out_valid3 && out_ready3) begin
        if (q3.size() == 0) chk("sb3_extra_key", 128'(q3.size()), 128'd1);
        else begin
          e = q3.pop_front();
          chk("sb3_key", rk_out3, e.k);
          chk("sb3_round", 128'(rk_round3), 128'(e.r));
          chk("sb3_last", 128'(rk_last3), 128'(e.l));
        end
      end
      st3 = out_valid3 && !out_ready3 && !abort;
      hk3 = rk_out3;
      hr3 = rk_round3;
      hl3 = rk_last3;
    end
  end

  initial begin
    logic [7:0] inv;
    logic [3:0] pat;
    logic       seen9;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                ^ rotl(inv, 4) ^ 8'h63;
    end

    rst_n      = 1'b1;
    key_in     = '0;
    in_valid   = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_out", rk_out, 128'd0);
    chk("rst_rk_round", 128'(rk_round), 128'd0);
    chk("rst_rk_last", 128'(rk_last), 128'd0);
    chk("rst_rcon", 128'(dut.rcon), 128'h01);
    #10 rst_n = 1'b1;
    step();

    // FIPS-197 A.1, no backpressure
    key_in    = bswap(KA);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    push_sched(KA, 10, 1'b0);
    step();
    in_valid = 1'b0;
    chk("a1_first_valid", 128'(out_valid), 128'd1);
    chk("a1_first_round", 128'(rk_round), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("a1_consecutive", 128'(rk_round), 128'(i));
      if (i == 1) chk("a1_round1", rk_out, bswap(R1A));
      if (i == 10) chk("a1_round10", rk_out, bswap(R10A));
      if (i == 10) chk("a1_last", 128'(rk_last), 128'd1);
    end
    step();
    chk("a1_in_ready_back", 128'(in_ready), 128'd1);
    chk("a1_out_valid_low", 128'(out_valid), 128'd0);

    // backpressure
    key_in   = bswap(KA);
    in_valid = 1'b1;
    push_sched(KA, 10, 1'b0);
    step();
    in_valid = 1'b0;
    pat      = 4'b1001;
    seen9    = 1'b0;
    for (int i = 0; i < 300 && busy; i++) begin
      out_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
      if (rk_round == 4'd9 && !seen9) begin
        chk("bp_rcon_round10", 128'(dut.rcon), 128'h36);
        seen9 = 1'b1;
      end
      step();
    end
    chk("bp_done", 128'(busy), 128'd0);
    chk("bp_saw_round9", 128'(seen9), 128'd1);
    out_ready = 1'b1;

    // abort at round 4, then abort blocking acceptance in IDLE
    key_in   = bswap(KA);
    in_valid = 1'b1;
    push_sched(KA, 10, 1'b0);
    step();
    in_valid = 1'b0;
    wait_round(4'd4);
    out_ready = 1'b0;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    q.delete();
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_rcon", 128'(dut.rcon), 128'h01);
    key_in   = bswap(KB);
    in_valid = 1'b1;
    abort    = 1'b1;
    step();
    chk("abort_idle_no_capture", 128'(out_valid), 128'd0);
    chk("abort_idle_in_ready", 128'(in_ready), 128'd1);
    abort     = 1'b0;
    out_ready = 1'b1;
    push_sched(KB, 10, 1'b0);
    step();
    in_valid = 1'b0;
    chk("kb_restart_round", 128'(rk_round), 128'd0);
    chk("kb_valid", 128'(out_valid), 128'd1);
    step();
    chk("kb_round1", rk_out, bswap(R1B));
    wait_idle();

    // back-to-back schedules
    key_in   = bswap(KA);
    in_valid = 1'b1;
    push_sched(KA, 10, 1'b0);
    step();
    key_in = bswap(KB);
    push_sched(KB, 10, 1'b0);
    wait_round(4'd10);
    step();
    chk("b2b_bubble_ready", 128'(in_ready), 128'd1);
    chk("b2b_bubble_valid", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    chk("b2b_second_valid", 128'(out_valid), 128'd1);
    chk("b2b_second_round", 128'(rk_round), 128'd0);
    chk("b2b_second_key", rk_out, bswap(KB));
    wait_idle();
    chk("b2b_queue_empty", 128'(q.size()), 128'd0);

    // async reset mid-schedule
    key_in   = bswap(KA);
    in_valid = 1'b1;
    push_sched(KA, 10, 1'b0);
    step();
    in_valid = 1'b0;
    wait_round(4'd7);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    chk("arst_rk_out", rk_out, 128'd0);
    chk("arst_rk_round", 128'(rk_round), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_no_glitch", 128'(out_valid), 128'd0);
    end

    // NROUNDS = 3 instance
    key_in     = bswap(KA);
    in_valid3  = 1'b1;
    out_ready3 = 1'b1;
    push_sched(KA, 3, 1'b1);
    step();
    in_valid3 = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      chk("n3_valid", 128'(out_valid3), 128'd1);
      chk("n3_round", 128'(rk_round3), 128'(i));
      chk("n3_last", 128'(rk_last3), 128'(i == 3));
      if (i == 2) chk("n3_rcon", 128'(dut3.rcon), 128'h04);
      step();
    end
    chk("n3_done_valid", 128'(out_valid3), 128'd0);
    chk("n3_done_ready", 128'(in_ready3), 128'd1);
    chk("n3_queue_empty", 128'(q3.size()), 128'd0);
    chk("main_queue_empty", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
